// File: rtl/ysyx_220066_pkg.sv
// Shared definitions for the ysyx_220066 load/store unit: memory-op encodings,
// FSM state encoding and size/legality helpers.
package ysyx_220066_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_D  = 3'b011;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;
  localparam logic [2:0] MEMOP_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Byte-enable pattern for an access of the given size, before lane shifting.
  function automatic logic [7:0] size_strb(input logic [1:0] size);
    logic [7:0] strb;
    case (size)
      2'd0:    strb = 8'h01;
      2'd1:    strb = 8'h03;
      2'd2:    strb = 8'h0F;
      default: strb = 8'hFF;
    endcase
    return strb;
  endfunction

  function automatic logic op_illegal(input logic wr, input logic [2:0] op);
    return (op == 3'b111) || (wr && op[2]);
  endfunction

endpackage

// File: rtl/ysyx_220066_lsu_align.sv
// Combinational lane logic: store strobes/shifted data, load extraction with
// sign/zero extension, and natural-alignment check.
module ysyx_220066_lsu_align
  import ysyx_220066_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [2:0]  off_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  wstrb_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o,
  output logic        misalign_o
);

  logic [5:0]  shamt;
  logic [63:0] raw;

  assign shamt = {off_i, 3'b000};

  always_comb begin
    wstrb_o = size_strb(op_i[1:0]) << off_i;
    wdata_o = wdata_i << shamt;
    raw     = rdata_i >> shamt;
    case (op_i)
      MEMOP_B:  rdata_o = {{56{raw[7]}}, raw[7:0]};
      MEMOP_H:  rdata_o = {{48{raw[15]}}, raw[15:0]};
      MEMOP_W:  rdata_o = {{32{raw[31]}}, raw[31:0]};
      MEMOP_BU: rdata_o = {56'd0, raw[7:0]};
      MEMOP_HU: rdata_o = {48'd0, raw[15:0]};
      MEMOP_WU: rdata_o = {32'd0, raw[31:0]};
      default:  rdata_o = raw;
    endcase
    case (op_i[1:0])
      2'd1:    misalign_o = off_i[0];
      2'd2:    misalign_o = |off_i[1:0];
      2'd3:    misalign_o = |off_i;
      default: misalign_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_220066_lsu.sv
// Load/store unit: turns one core memory op into one handshaked 64-bit bus
// transaction and stalls the core until it retires.
module ysyx_220066_lsu
  import ysyx_220066_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_valid,
  input  logic        cpu_wr,
  input  logic [2:0]  cpu_op,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [63:0] lsu_rdata,
  output logic        lsu_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [63:0] bus_addr,
  output logic        bus_wen,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [63:0] bus_rsp_data,
  input  logic        bus_rsp_err
);

  lsu_state_e  state_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [2:0]  op_q;
  logic        wr_q;
  logic [31:0] cnt_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic        inIdle;
  logic [2:0]  alignOp;
  logic [2:0]  alignOff;
  logic [7:0]  alignStrb;
  logic [63:0] alignWdata;
  logic [63:0] alignRdata;
  logic        alignMisalign;
  logic        reqIllegal;
  logic        timeoutHit;

  // In IDLE the aligner judges the incoming request; afterwards it works on the captured one.
  assign inIdle   = (state_q == ST_IDLE);
  assign alignOp  = inIdle ? cpu_op : op_q;
  assign alignOff = inIdle ? cpu_addr[2:0] : addr_q[2:0];

  ysyx_220066_lsu_align u_align (
    .op_i       (alignOp),
    .off_i      (alignOff),
    .wdata_i    (wdata_q),
    .rdata_i    (bus_rsp_data),
    .wstrb_o    (alignStrb),
    .wdata_o    (alignWdata),
    .rdata_o    (alignRdata),
    .misalign_o (alignMisalign)
  );

  assign reqIllegal = op_illegal(cpu_wr, cpu_op) || alignMisalign;
  assign timeoutHit = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_valid) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            op_q    <= cpu_op;
            wr_q    <= cpu_wr;
            if (reqIllegal) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          cnt_q <= '0;
          if (bus_req_ready) state_q <= ST_RSP;
        end
        ST_RSP: begin
          // A response arriving on the timeout cycle still wins.
          if (bus_rsp_valid) begin
            err_q   <= bus_rsp_err;
            rdata_q <= (bus_rsp_err || wr_q) ? 64'd0 : alignRdata;
            state_q <= ST_DONE;
          end else if (timeoutHit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
          err_q   <= 1'b0;
          rdata_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign lsu_busy      = (state_q == ST_REQ) || (state_q == ST_RSP) || (inIdle && cpu_valid);
  assign lsu_done      = (state_q == ST_DONE);
  assign lsu_rdata     = rdata_q;
  assign lsu_err       = err_q;
  assign bus_req_valid = (state_q == ST_REQ);
  assign bus_addr      = bus_req_valid ? {addr_q[63:3], 3'b000} : 64'd0;
  assign bus_wen       = bus_req_valid && wr_q;
  assign bus_wdata     = bus_wen ? alignWdata : 64'd0;
  assign bus_wstrb     = bus_wen ? alignStrb : 8'h00;

endmodule

// File: tb/tb_ysyx_220066_lsu.sv
// Directed bench for the load/store unit: table of single transactions plus
// hand-written stall, timeout and reset sequences.
module tb_ysyx_220066_lsu;

  logic        clk;
  logic        rst;
  logic        cpu_valid;
  logic        cpu_wr;
  logic [2:0]  cpu_op;
  logic [63:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic        lsu_busy;
  logic        lsu_done;
  logic [63:0] lsu_rdata;
  logic        lsu_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [63:0] bus_addr;
  logic        bus_wen;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic [63:0] bus_rsp_data;
  logic        bus_rsp_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rsp;
    logic        rspErr;
    int          expLat;
    logic        expErr;
    logic [63:0] expRdata;
    logic [63:0] expWdata;
    logic [7:0]  expStrb;
  } vec_t;

  vec_t vecs[14];

  ysyx_220066_lsu #(.TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_valid     (cpu_valid),
    .cpu_wr        (cpu_wr),
    .cpu_op        (cpu_op),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .lsu_busy      (lsu_busy),
    .lsu_done      (lsu_done),
    .lsu_rdata     (lsu_rdata),
    .lsu_err       (lsu_err),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_wen       (bus_wen),
    .bus_wdata     (bus_wdata),
    .bus_wstrb     (bus_wstrb),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_data  (bus_rsp_data),
    .bus_rsp_err   (bus_rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one request with ready and response held high, then follow it to retirement.
  task automatic applyStimulus(input vec_t v);
    logic sawReq;
    logic got;
    int   lat;
    sawReq        = 1'b0;
    got           = 1'b0;
    lat           = 0;
    cpu_valid     = 1'b1;
    cpu_wr        = v.wr;
    cpu_op        = v.op;
    cpu_addr      = v.addr;
    cpu_wdata     = v.wdata;
    bus_req_ready = 1'b1;
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = v.rsp;
    bus_rsp_err   = v.rspErr;
    #1;
    checkOutput("busy_on_request", 64'(lsu_busy), 64'd1);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      lat = cyc;
      if (bus_req_valid && !sawReq) begin
        sawReq = 1'b1;
        checkOutput("bus_addr", bus_addr, {v.addr[63:3], 3'b000});
        checkOutput("bus_wen", 64'(bus_wen), 64'(v.wr));
        checkOutput("bus_wstrb", 64'(bus_wstrb), 64'(v.expStrb));
        if (v.wr) checkOutput("bus_wdata", bus_wdata, v.expWdata);
      end
      if (lsu_done) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", 64'(got), 64'd1);
    checkOutput("latency", 64'(lat), 64'(v.expLat));
    checkOutput("req_seen", 64'(sawReq), 64'(v.expLat == 3));
    checkOutput("lsu_err", 64'(lsu_err), 64'(v.expErr));
    checkOutput("lsu_rdata", lsu_rdata, v.expRdata);
    checkOutput("busy_in_done", 64'(lsu_busy), 64'd0);
    cpu_valid     = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    tick();
    checkOutput("done_one_cycle", 64'(lsu_done), 64'd0);
  endtask

  initial begin
    int n;
    logic got;
    vecs[0]  = '{1'b0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 3, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 64'h0, 8'h00};
    vecs[1]  = '{1'b1, 3'b001, 64'h2006, 64'h1234, 64'h0, 1'b0, 3, 1'b0, 64'h0, 64'h1234_0000_0000_0000, 8'hC0};
    vecs[2]  = '{1'b0, 3'b010, 64'h3002, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 1'b1, 64'h0, 64'h0, 8'h00};
    vecs[3]  = '{1'b0, 3'b101, 64'h5006, 64'h0, 64'h8765_0000_0000_0000, 1'b0, 3, 1'b0, 64'h0000_0000_0000_8765, 64'h0, 8'h00};
    vecs[4]  = '{1'b0, 3'b001, 64'h5006, 64'h0, 64'h8765_0000_0000_0000, 1'b0, 3, 1'b0, 64'hFFFF_FFFF_FFFF_8765, 64'h0, 8'h00};
    vecs[5]  = '{1'b0, 3'b011, 64'h6000, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0, 8'h00};
    vecs[6]  = '{1'b1, 3'b000, 64'h7005, 64'hAB, 64'h0, 1'b0, 3, 1'b0, 64'h0, 64'h0000_AB00_0000_0000, 8'h20};
    vecs[7]  = '{1'b1, 3'b010, 64'h8004, 64'hDEAD_BEEF, 64'h0, 1'b0, 3, 1'b0, 64'h0, 64'hDEAD_BEEF_0000_0000, 8'hF0};
    vecs[8]  = '{1'b1, 3'b100, 64'h8000, 64'h55, 64'h0, 1'b0, 1, 1'b1, 64'h0, 64'h0, 8'h00};
    vecs[9]  = '{1'b0, 3'b111, 64'h8000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 1'b1, 64'h0, 64'h0, 8'h00};
    vecs[10] = '{1'b0, 3'b010, 64'h9004, 64'h0, 64'h8000_0001_0000_0000, 1'b0, 3, 1'b0, 64'hFFFF_FFFF_8000_0001, 64'h0, 8'h00};
    vecs[11] = '{1'b0, 3'b000, 64'hA000, 64'h0, 64'h0000_0000_0000_00FF, 1'b1, 3, 1'b1, 64'h0, 64'h0, 8'h00};
    vecs[12] = '{1'b1, 3'b011, 64'hB000, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 3, 1'b0, 64'h0, 64'h1122_3344_5566_7788, 8'hFF};
    vecs[13] = '{1'b0, 3'b011, 64'hC004, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 1'b1, 64'h0, 64'h0, 8'h00};

    rst           = 1'b1;
    cpu_valid     = 1'b0;
    cpu_wr        = 1'b0;
    cpu_op        = 3'b000;
    cpu_addr      = 64'h0;
    cpu_wdata     = 64'h0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_data  = 64'h0;
    bus_rsp_err   = 1'b0;
    #12;
    checkOutput("reset_busy", 64'(lsu_busy), 64'd0);
    checkOutput("reset_done", 64'(lsu_done), 64'd0);
    checkOutput("reset_err", 64'(lsu_err), 64'd0);
    checkOutput("reset_rdata", lsu_rdata, 64'd0);
    checkOutput("reset_req_valid", 64'(bus_req_valid), 64'd0);
    checkOutput("reset_wstrb", 64'(bus_wstrb), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
    end

    // Response with nothing outstanding must not retire anything.
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = 64'h1234;
    tick();
    tick();
    checkOutput("idle_rsp_done", 64'(lsu_done), 64'd0);
    checkOutput("idle_rsp_req", 64'(bus_req_valid), 64'd0);
    bus_rsp_valid = 1'b0;

    // LWU with the bus stalled; core inputs change meanwhile and must be ignored.
    cpu_valid     = 1'b1;
    cpu_wr        = 1'b0;
    cpu_op        = 3'b110;
    cpu_addr      = 64'h4004;
    bus_req_ready = 1'b0;
    tick();
    cpu_addr = 64'h9999_0001;
    cpu_op   = 3'b000;
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_req_valid", 64'(bus_req_valid), 64'd1);
      checkOutput("stall_addr", bus_addr, 64'h4000);
      checkOutput("stall_busy", 64'(lsu_busy), 64'd1);
      tick();
    end
    bus_req_ready = 1'b1;
    tick();
    checkOutput("rsp_busy", 64'(lsu_busy), 64'd1);
    checkOutput("rsp_req_dropped", 64'(bus_req_valid), 64'd0);
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = 64'hF000_0000_0000_0000;
    got = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (lsu_done) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("lwu_done", 64'(got), 64'd1);
    checkOutput("lwu_rdata", lsu_rdata, 64'h0000_0000_F000_0000);
    checkOutput("lwu_err", 64'(lsu_err), 64'd0);
    cpu_valid     = 1'b0;
    bus_rsp_valid = 1'b0;
    tick();

    // LD with no response: must time out exactly 16 cycles after entering RSP.
    cpu_valid     = 1'b1;
    cpu_op        = 3'b011;
    cpu_addr      = 64'hD000;
    bus_req_ready = 1'b1;
    tick();
    tick();
    cpu_valid     = 1'b0;
    bus_req_ready = 1'b0;
    n   = 0;
    got = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      n = k;
      if (lsu_done) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("timeout_done", 64'(got), 64'd1);
    checkOutput("timeout_cycles", 64'(n), 64'd16);
    checkOutput("timeout_err", 64'(lsu_err), 64'd1);
    checkOutput("timeout_rdata", lsu_rdata, 64'd0);
    tick();

    // Reset while waiting in RSP, then a fresh LD must complete normally.
    cpu_valid     = 1'b1;
    cpu_op        = 3'b011;
    cpu_addr      = 64'hE000;
    bus_req_ready = 1'b1;
    tick();
    tick();
    tick();
    cpu_valid     = 1'b0;
    bus_req_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(lsu_busy), 64'd0);
    checkOutput("midrst_req_valid", 64'(bus_req_valid), 64'd0);
    checkOutput("midrst_done", 64'(lsu_done), 64'd0);
    #3;
    rst = 1'b0;
    tick();
    applyStimulus('{1'b0, 3'b011, 64'hE008, 64'h0, 64'hCAFE_F00D_0BAD_BEEF, 1'b0, 3, 1'b0, 64'hCAFE_F00D_0BAD_BEEF, 64'h0, 8'h00});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
